present_byte_if: RTL and testbench

Byte-serial front end for the iterative PRESENT-80 encryption core. It deserialises a 10-byte key and an 8-byte plaintext from a valid/ready byte stream and presents them as stable 80/64-bit operands to the core. It tracks the core's fixed 32-cycle schedule with a mirror phase counter, captures the 64-bit ciphertext at the correct cycle, and serialises it back out as 8 bytes on a second valid/ready stream. It sits directly upstream of the core (operands) and directly downstream of it (result).

---
 rtl/present_pkg.sv | 20 ++
 rtl/present_byte_if_if.sv | 11 +
 rtl/present_obuf.sv | 42 ++++
 rtl/present_byte_if.sv | 90 +++++++++
 tb/tb_present_byte_if.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/present_pkg.sv
// Shared constants and types for the PRESENT-80 byte-serial front end.
package present_pkg;

  localparam int unsigned KEY_BYTES = 10;
  localparam int unsigned BLK_BYTES = 8;
  localparam int unsigned PERIOD    = 32;

  localparam int unsigned KEY_W   = 8 * KEY_BYTES;
  localparam int unsigned BLK_W   = 8 * BLK_BYTES;
  localparam int unsigned IDX_W   = $clog2(KEY_BYTES + BLK_BYTES);
  localparam int unsigned OIDX_W  = $clog2(BLK_BYTES);
  localparam int unsigned PHASE_W = $clog2(PERIOD);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ARMED = 2'd1,
    BUSY  = 2'd2
  } in_state_e;

endpackage

// File: rtl/present_byte_if_if.sv
// Byte-wide valid/ready stream used for both the operand and ciphertext sides.
interface byte_stream_if;

  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/present_obuf.sv
// Single-block ciphertext buffer that drains one byte per handshake, MSB byte first.
module present_obuf
  import present_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic [0:BLK_W-1] din,
  output logic             valid,
  output logic [7:0]       data,
  input  logic             ready
);

  localparam logic [OIDX_W-1:0] LAST_BYTE = OIDX_W'(BLK_BYTES - 1);

  logic [0:BLK_W-1]  buffer;
  logic [OIDX_W-1:0] idx;

  // The buffer shifts on each handshake, so the current byte is always the head.
  assign data = buffer[0:7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buffer <= '0;
      idx    <= '0;
      valid  <= 1'b0;
    end else if (capture && !valid) begin
      buffer <= din;
      idx    <= '0;
      valid  <= 1'b1;
    end else if (valid && ready) begin
      buffer <= {buffer[8:BLK_W-1], 8'h00};
      if (idx == LAST_BYTE) begin
        idx   <= '0;
        valid <= 1'b0;
      end else begin
        idx <= idx + OIDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/present_byte_if.sv
// Deserialises key/plaintext for the PRESENT-80 core, tracks its 32-cycle schedule
// and serialises the captured ciphertext.
module present_byte_if
  import present_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  byte_stream_if.slave     in_stream,
  byte_stream_if.master    out_stream,
  output logic [0:KEY_W-1] core_keys,
  output logic [0:BLK_W-1] core_state,
  input  logic [0:BLK_W-1] core_result
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_BYTES + BLK_BYTES - 1);

  in_state_e          state;
  logic [IDX_W-1:0]   idx;
  logic [PHASE_W-1:0] phase;
  logic               in_ready_q;
  logic               phase_zero;
  logic               capture;
  logic               obuf_valid;
  logic [7:0]         obuf_data;

  assign phase_zero = (phase == '0);
  // Full is sampled before the edge, so a draining final byte still blocks capture.
  assign capture    = (state == BUSY) && phase_zero && !obuf_valid;

  assign in_stream.ready  = in_ready_q;
  assign out_stream.valid = obuf_valid;
  assign out_stream.data  = obuf_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      idx        <= '0;
      phase      <= '0;
      in_ready_q <= 1'b1;
      core_keys  <= '0;
      core_state <= '0;
    end else begin
      phase <= phase + PHASE_W'(1);
      unique case (state)
        FILL: begin
          if (in_stream.valid && in_ready_q) begin
            for (int unsigned i = 0; i < KEY_BYTES; i++) begin
              if (idx == IDX_W'(i)) core_keys[8*i +: 8] <= in_stream.data;
            end
            for (int unsigned i = 0; i < BLK_BYTES; i++) begin
              if (idx == IDX_W'(KEY_BYTES + i)) core_state[8*i +: 8] <= in_stream.data;
            end
            if (idx == LAST_IDX) begin
              idx        <= '0;
              state      <= ARMED;
              in_ready_q <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        ARMED: begin
          if (phase_zero) state <= BUSY;
        end
        BUSY: begin
          // Without capture the held operands make the core recompute the same block.
          if (capture) begin
            state      <= FILL;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= FILL;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  present_obuf u_obuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (capture),
    .din     (core_result),
    .valid   (obuf_valid),
    .data    (obuf_data),
    .ready   (out_stream.ready)
  );

endmodule

// File: tb/tb_present_byte_if.sv
// Bench for present_byte_if: PRESENT-80 core model on the operand/result ports,
// byte scoreboard on the output stream, directed and random blocks.
module tb_present_byte_if;
  import present_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  byte_stream_if in_bus ();
  byte_stream_if out_bus ();

  logic [0:79] core_keys;
  logic [0:63] core_state;
  logic [63:0] core_result = '0;

  present_byte_if dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_stream   (in_bus),
    .out_stream  (out_bus),
    .core_keys   (core_keys),
    .core_state  (core_state),
    .core_result (core_result)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int mode = 0;
  int drained = 0;
  int acc_cyc, acc_phase;
  logic [4:0]  tb_phase;
  logic [79:0] ld_k;
  logic [63:0] ld_s;
  logic [7:0]  sb[$];
  int rise_q[$], fin_q[$], acc_q[$], ph_q[$];
  bit prev_valid = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic flag(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: observed timeout/no event expected event", tag);
  endtask

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h2174_8FE3_DA09_B65C;
    return tbl[4*x +: 4];
  endfunction

  function automatic logic [63:0] present80(input logic [79:0] key, input logic [63:0] pt);
    logic [79:0] k;
    logic [63:0] s, p;
    k = key;
    s = pt;
    p = '0;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox(s[4*n +: 4]);
      for (int b = 0; b < 64; b++) p[(b == 63) ? 63 : (b * 16) % 63] = s[b];
      s = p;
      k = {k[18:0], k[79:19]};
      k[79:76] = sbox(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  // Core schedule mirror: loads at phase 0, shows its ciphertext just before the next phase 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_phase <= '0;
      ld_k     <= '0;
      ld_s     <= '0;
    end else begin
      tb_phase <= tb_phase + 5'd1;
      if (tb_phase == 5'd0) begin
        ld_k <= core_keys;
        ld_s <= core_state;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tb_phase == 5'd0) core_result = present80(ld_k, ld_s);
    else                  core_result = {$urandom, $urandom};
  end

  // Output monitor: scoreboard, stall stability, rise and final-byte timestamps.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      out_bus.ready = 1'b0;
    end else begin
      if (prev_valid && out_bus.ready) begin
        if (sb.size() == 0) flag("out_unexpected");
        else check("out_byte", prev_data, sb.pop_front());
        drained++;
        if (drained % 8 == 0) fin_q.push_back(cyc);
      end else if (prev_valid) begin
        check("stall_valid", out_bus.valid, 1);
        check("stall_data", out_bus.data, prev_data);
      end
      if (out_bus.valid && !prev_valid) rise_q.push_back(cyc);
      prev_valid = out_bus.valid;
      prev_data  = out_bus.data;
      case (mode)
        0:       out_bus.ready = 1'b1;
        1:       out_bus.ready = 1'($urandom_range(0, 1));
        default: out_bus.ready = 1'b0;
      endcase
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps, input int want_phase);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 2000) begin
      @(negedge clk);
      in_bus.data  = b;
      in_bus.valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (want_phase >= 0 && int'(tb_phase) != want_phase) in_bus.valid = 1'b0;
      if (in_bus.valid && in_bus.ready) begin
        done      = 1'b1;
        acc_cyc   = cyc + 1;
        acc_phase = int'(tb_phase);
      end
      n++;
    end
    if (!done) flag("in_accept");
  endtask

  task automatic send_block(input logic [79:0] key, input logic [63:0] pt,
                            input logic [63:0] ct, input bit gaps, input int last_phase);
    logic [143:0] blk;
    blk = {key, pt};
    for (int i = 0; i < KEY_BYTES + BLK_BYTES; i++)
      send_byte(blk[143 - 8*i -: 8], gaps, (i == 17) ? last_phase : -1);
    acc_q.push_back(acc_cyc);
    ph_q.push_back(acc_phase);
    for (int i = 0; i < BLK_BYTES; i++) sb.push_back(ct[63 - 8*i -: 8]);
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_bus.valid = 1'b0;
  endtask

  // Edge at which a block whose last byte was accepted at acc_q[k] is captured into an empty buffer.
  function automatic int exp_rise(input int k);
    return acc_q[k] + ((ph_q[k] == 0) ? 32 : 32 - ph_q[k]) + 32;
  endfunction

  task automatic wait_rise(input int n, input string tag);
    int t = 0;
    while (rise_q.size() < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (rise_q.size() < n) flag(tag);
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) flag(tag);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_idle_valid"}, out_bus.valid, 0);
  endtask

  task automatic new_test();
    acc_q.delete();
    ph_q.delete();
    rise_q.delete();
    fin_q.delete();
  endtask

  localparam logic [79:0] K0 = '0;
  localparam logic [79:0] KF = '1;
  localparam logic [63:0] P0 = '0;
  localparam logic [63:0] PF = '1;

  initial begin
    logic [79:0] key;
    logic [63:0] pt;
    logic [143:0] blk;
    int cap;

    rst_n = 1'b0;
    in_bus.valid = 1'b0;
    in_bus.data  = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_bus.ready, 1);
    check("rst_out_valid", out_bus.valid, 0);
    check("rst_out_data", out_bus.data, 0);
    check("rst_keys", core_keys, 0);
    check("rst_state", core_state, 0);
    #2 rst_n = 1'b1;

    // All-zero block, latency from the load edge.
    new_test();
    mode = 0;
    send_block(K0, P0, 64'h5579_C138_7B22_8445, 1'b0, -1);
    idle_in();
    wait_rise(1, "t1_rise_wait");
    if (rise_q.size() >= 1) check("t1_rise_cycle", rise_q[0], exp_rise(0));
    wait_drain("t1_drain");

    // Last byte at phase 5: load 27 cycles later, result 32 after that.
    new_test();
    blk = {KF, P0};
    for (int i = 0; i < 17; i++) send_byte(blk[143 - 8*i -: 8], 1'b0, -1);
    send_byte(blk[7:0], 1'b0, 5);
    acc_q.push_back(acc_cyc);
    ph_q.push_back(acc_phase);
    for (int i = 0; i < 8; i++) sb.push_back(8'(64'hE72C_46C0_F594_5049 >> (56 - 8*i)));
    idle_in();
    wait_rise(1, "t2_rise_wait");
    if (rise_q.size() >= 1) check("t2_rise_cycle", rise_q[0], acc_q[0] + 27 + 32);
    wait_drain("t2_drain");

    // Back-to-back blocks with in_valid held high through ARMED/BUSY.
    new_test();
    send_block(K0, PF, 64'hA112_FFC7_2F68_417B, 1'b0, -1);
    send_block(KF, PF, 64'h3333_DCD3_2132_10D2, 1'b0, -1);
    idle_in();
    wait_rise(2, "t3_rise_wait");
    if (rise_q.size() >= 2) begin
      check("t3_rise0", rise_q[0], exp_rise(0));
      check("t3_rise1", rise_q[1], exp_rise(1));
    end
    wait_drain("t3_drain");

    // Sink stalled; block 1's final byte lands on block 2's capture edge, so capture retries.
    new_test();
    mode = 2;
    send_block(K0, P0, 64'h5579_C138_7B22_8445, 1'b0, -1);
    send_block(KF, P0, 64'hE72C_46C0_F594_5049, 1'b0, -1);
    idle_in();
    cap = exp_rise(1);
    while (cap < cyc + 50) cap += 32;
    while (cyc < cap - 9) @(negedge clk);
    @(posedge clk);
    mode = 0;
    wait_rise(2, "t4_rise_wait");
    if (fin_q.size() >= 1) check("t4_final_edge", fin_q[0], cap);
    if (rise_q.size() >= 2) check("t4_retry_rise", rise_q[1], cap + 32);
    wait_drain("t4_drain");

    // Reset in the middle of a block discards it.
    new_test();
    key = 80'h0123_4567_89AB_CDEF_FEDC;
    pt  = 64'hBA98_7654_3210_1357;
    blk = {key, pt};
    for (int i = 0; i < 12; i++) send_byte(blk[143 - 8*i -: 8], 1'b0, -1);
    idle_in();
    check("partial_keys", core_keys, key);
    check("partial_state", core_state, {pt[63:48], 48'h0});
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_bus.ready, 1);
    check("mid_rst_out_valid", out_bus.valid, 0);
    check("mid_rst_keys", core_keys, 0);
    check("mid_rst_state", core_state, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    send_block(K0, PF, 64'hA112_FFC7_2F68_417B, 1'b0, -1);
    idle_in();
    wait_drain("t5_drain");

    // Random blocks with random input gaps and sink back-pressure.
    new_test();
    mode = 1;
    for (int b = 0; b < 6; b++) begin
      key = {$urandom, $urandom, 16'($urandom)};
      pt  = {$urandom, $urandom};
      send_block(key, pt, present80(key, pt), 1'b1, -1);
    end
    idle_in();
    wait_drain("t6_drain");
    mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
